// File: rtl/sign_mag_pkg.sv
// Shared sign-magnitude helpers for the adder/subtractor pair.
// Compare/select is width-generic via zero-extension to MAX_W bits.
package sign_mag_pkg;

    localparam int MAX_W = 64;
    localparam logic [MAX_W-1:0] POS_ZERO = '0;

    typedef struct packed {
        logic swap;
        logic sign;
        logic op_add;
    } sel_t;

    function automatic int sign_pos(input int n);
        return n - 1;
    endfunction

    function automatic int mag_w(input int n);
        return n - 1;
    endfunction

    // b_sign is the effective sign: raw for add, inverted for subtract
    function automatic sel_t sm_select(
        input logic [MAX_W-1:0] a_mag,
        input logic [MAX_W-1:0] b_mag,
        input logic             a_sign,
        input logic             b_sign
    );
        sel_t r;
        r.swap   = !(a_mag > b_mag);
        r.sign   = r.swap ? b_sign : a_sign;
        r.op_add = (a_sign == b_sign);
        return r;
    endfunction

endpackage

// File: rtl/sign_mag_sel.sv
// Combinational compare/select for a - b in sign-magnitude form.
// Orders magnitudes and picks the result sign and operation.
module sign_mag_sel
    import sign_mag_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-2:0] max_mag,
    output logic [N-2:0] min_mag,
    output logic         sign,
    output logic         op_add
);

    localparam int SP = sign_pos(N);
    localparam int MW = mag_w(N);

    logic [MW-1:0] a_mag;
    logic [MW-1:0] b_mag;
    logic          bs;
    sel_t          sel;

    assign a_mag = a[MW-1:0];
    assign b_mag = b[MW-1:0];
    assign bs    = ~b[SP];

    assign sel = sm_select(
        {{(MAX_W-MW){1'b0}}, a_mag},
        {{(MAX_W-MW){1'b0}}, b_mag},
        a[SP],
        bs
    );

    assign max_mag = sel.swap ? b_mag : a_mag;
    assign min_mag = sel.swap ? a_mag : b_mag;
    assign sign    = sel.sign;
    assign op_add  = sel.op_add;

endmodule

// File: rtl/sign_mag_sub_pipe.sv
// Two-stage sign-magnitude subtractor with valid/ready on both sides.
// Stage 1 registers compare/select, stage 2 registers the result.
module sign_mag_sub_pipe
    import sign_mag_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         ovf,
    output logic         zero
);

    localparam int SP = sign_pos(N);
    localparam int MW = mag_w(N);

    logic [MW-1:0] sel_max;
    logic [MW-1:0] sel_min;
    logic          sel_sign;
    logic          sel_op_add;

    logic          s1_valid;
    logic [MW-1:0] s1_max;
    logic [MW-1:0] s1_min;
    logic          s1_sign;
    logic          s1_op_add;
    logic          s2_valid;

    logic          s1_load;
    logic          s2_load;

    logic [N-1:0]  sum;
    logic [MW-1:0] mag_c;
    logic          ovf_c;
    logic [N-1:0]  diff_c;
    logic          zero_c;

    sign_mag_sel #(.N(N)) u_sel (
        .a       (a),
        .b       (b),
        .max_mag (sel_max),
        .min_mag (sel_min),
        .sign    (sel_sign),
        .op_add  (sel_op_add)
    );

    assign s2_load   = !s2_valid || out_ready;
    assign s1_load   = !s1_valid || s2_load;
    assign in_ready  = s1_load;
    assign out_valid = s2_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_max    <= '0;
            s1_min    <= '0;
            s1_sign   <= 1'b0;
            s1_op_add <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_max    <= sel_max;
                s1_min    <= sel_min;
                s1_sign   <= sel_sign;
                s1_op_add <= sel_op_add;
            end
        end
    end

    // Add path is N bits wide so the carry lands in the sign slot as ovf
    always_comb begin
        sum    = {1'b0, s1_max} + {1'b0, s1_min};
        mag_c  = s1_max - s1_min;
        ovf_c  = 1'b0;
        diff_c = POS_ZERO[N-1:0];
        zero_c = 1'b0;
        if (s1_op_add) begin
            mag_c = sum[MW-1:0];
            ovf_c = sum[SP];
        end
        if (!ovf_c && mag_c == '0) begin
            zero_c = 1'b1;
        end else begin
            diff_c = {s1_sign, mag_c};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            diff     <= '0;
            ovf      <= 1'b0;
            zero     <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                diff <= diff_c;
                ovf  <= ovf_c;
                zero <= zero_c;
            end
        end
    end

endmodule

// File: tb/tb_sign_mag_sub_pipe.sv
// Directed bench for sign_mag_sub_pipe (N=4).
// Streaming scenario uses an integer reference model.
module tb_sign_mag_sub_pipe;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [N-1:0] diff;
    logic         ovf;
    logic         zero;

    int n_cmp = 0;
    int n_fail = 0;

    sign_mag_sub_pipe #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns {diff, ovf, zero} from signed integer arithmetic
    function automatic logic [N+1:0] model(
        input logic [N-1:0] x,
        input logic [N-1:0] y
    );
        int xv, yv, d, m;
        logic s, o;
        logic [N-2:0] mv;
        xv = int'(x[N-2:0]);
        yv = int'(y[N-2:0]);
        if (x[N-1]) xv = -xv;
        if (y[N-1]) yv = -yv;
        d = xv - yv;
        s = (d < 0);
        m = s ? -d : d;
        o = (m > (1 << (N-1)) - 1);
        mv = m[N-2:0];
        if (!o && mv == '0) return {{N{1'b0}}, 1'b0, 1'b1};
        return {s, mv, o, 1'b0};
    endfunction

    task automatic xfer(
        input  logic [N-1:0] ta,
        input  logic [N-1:0] tb,
        output logic         v1
    );
        a = ta;
        b = tb;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        v1 = out_valid;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, diff, ovf, zero} !== '0) begin
            n_fail++;
            $display("FAIL reset_out got=%b want=0",
                     {out_valid, diff, ovf, zero});
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        tick();
    endtask

    task automatic test_same_sign();
        logic v1;
        xfer(4'b0011, 4'b0001, v1);
        n_cmp++;
        if (v1 !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early got=%b want=0", v1);
        end
        n_cmp++;
        if ({out_valid, diff, ovf, zero} !== {1'b1, 4'b0010, 2'b00}) begin
            n_fail++;
            $display("FAIL same_sign got=%b want=%b",
                     {out_valid, diff, ovf, zero}, {1'b1, 4'b0010, 2'b00});
        end
    endtask

    task automatic test_sign_flip();
        logic v1;
        xfer(4'b0011, 4'b0101, v1);
        n_cmp++;
        if ({out_valid, diff, ovf, zero} !== {1'b1, 4'b1010, 2'b00}) begin
            n_fail++;
            $display("FAIL flip_3m5 got=%b want=%b",
                     {out_valid, diff, ovf, zero}, {1'b1, 4'b1010, 2'b00});
        end
        xfer(4'b1001, 4'b0010, v1);
        n_cmp++;
        if ({out_valid, diff, ovf, zero} !== {1'b1, 4'b1011, 2'b00}) begin
            n_fail++;
            $display("FAIL flip_m1m2 got=%b want=%b",
                     {out_valid, diff, ovf, zero}, {1'b1, 4'b1011, 2'b00});
        end
    endtask

    task automatic test_overflow();
        logic v1;
        xfer(4'b0110, 4'b1011, v1);
        n_cmp++;
        if ({out_valid, diff, ovf, zero} !== {1'b1, 4'b0001, 2'b10}) begin
            n_fail++;
            $display("FAIL ovf_9 got=%b want=%b",
                     {out_valid, diff, ovf, zero}, {1'b1, 4'b0001, 2'b10});
        end
        xfer(4'b0101, 4'b1011, v1);
        n_cmp++;
        if ({out_valid, diff, ovf, zero} !== {1'b1, 4'b0000, 2'b10}) begin
            n_fail++;
            $display("FAIL ovf_8 got=%b want=%b",
                     {out_valid, diff, ovf, zero}, {1'b1, 4'b0000, 2'b10});
        end
        xfer(4'b1101, 4'b0011, v1);
        n_cmp++;
        if ({out_valid, diff, ovf, zero} !== {1'b1, 4'b1000, 2'b10}) begin
            n_fail++;
            $display("FAIL ovf_neg8 got=%b want=%b",
                     {out_valid, diff, ovf, zero}, {1'b1, 4'b1000, 2'b10});
        end
    endtask

    task automatic test_zero_norm();
        logic v1;
        xfer(4'b1010, 4'b1010, v1);
        n_cmp++;
        if ({out_valid, diff, ovf, zero} !== {1'b1, 4'b0000, 2'b01}) begin
            n_fail++;
            $display("FAIL zero_eq got=%b want=%b",
                     {out_valid, diff, ovf, zero}, {1'b1, 4'b0000, 2'b01});
        end
        xfer(4'b1000, 4'b0000, v1);
        n_cmp++;
        if ({out_valid, diff, ovf, zero} !== {1'b1, 4'b0000, 2'b01}) begin
            n_fail++;
            $display("FAIL zero_negz got=%b want=%b",
                     {out_valid, diff, ovf, zero}, {1'b1, 4'b0000, 2'b01});
        end
        xfer(4'b0000, 4'b1000, v1);
        n_cmp++;
        if ({out_valid, diff, ovf, zero} !== {1'b1, 4'b0000, 2'b01}) begin
            n_fail++;
            $display("FAIL zero_subnegz got=%b want=%b",
                     {out_valid, diff, ovf, zero}, {1'b1, 4'b0000, 2'b01});
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] ta [3];
        logic [N-1:0] tb [3];
        logic [N+1:0] te [3];
        ta[0] = 4'b0010; tb[0] = 4'b0001; te[0] = {4'b0001, 2'b00};
        ta[1] = 4'b0001; tb[1] = 4'b0111; te[1] = {4'b1110, 2'b00};
        ta[2] = 4'b1011; tb[2] = 4'b1001; te[2] = {4'b1010, 2'b00};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i < 3);
            if (i < 3) begin
                a = ta[i];
                b = tb[i];
            end
            tick();
            if (i >= 1 && i <= 3) begin
                n_cmp++;
                if ({out_valid, diff, ovf, zero} !== {1'b1, te[i-1]}) begin
                    n_fail++;
                    $display("FAIL b2b_%0d got=%b want=%b", i - 1,
                             {out_valid, diff, ovf, zero}, {1'b1, te[i-1]});
                end
            end
            if (i == 4) begin
                n_cmp++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_drain got=%b want=0", out_valid);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] pa [6];
        logic [N-1:0] pb [6];
        logic [N+1:0] q [$];
        logic [N+1:0] held_res;
        logic         held;
        int sent, got, occ, low_cnt;
        pa[0] = 4'b0101; pb[0] = 4'b0010;
        pa[1] = 4'b1111; pb[1] = 4'b0111;
        pa[2] = 4'b0011; pb[2] = 4'b1100;
        pa[3] = 4'b1000; pb[3] = 4'b0110;
        pa[4] = 4'b0111; pb[4] = 4'b1111;
        pa[5] = 4'b0000; pb[5] = 4'b0001;
        sent = 0; got = 0; occ = 0; low_cnt = 0;
        held = 1'b0;
        held_res = '0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            in_valid = (sent < 6);
            if (sent < 6) begin
                a = pa[sent];
                b = pb[sent];
            end
            out_ready = !(c >= 3 && c <= 5);
            #1;
            n_cmp++;
            if (in_ready !== !(occ == 2 && !out_ready)) begin
                n_fail++;
                $display("FAIL bp_in_ready c=%0d got=%b want=%b",
                         c, in_ready, !(occ == 2 && !out_ready));
            end
            if (!in_ready) low_cnt++;
            if (held) begin
                n_cmp++;
                if ({out_valid, diff, ovf, zero} !== {1'b1, held_res}) begin
                    n_fail++;
                    $display("FAIL bp_hold c=%0d got=%b want=%b", c,
                             {out_valid, diff, ovf, zero}, {1'b1, held_res});
                end
            end
            held = out_valid && !out_ready;
            held_res = {diff, ovf, zero};
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q.size() == 0 || {diff, ovf, zero} !== q[0]) begin
                    n_fail++;
                    $display("FAIL bp_order n=%0d got=%b want=%b", got,
                             {diff, ovf, zero},
                             (q.size() == 0) ? '0 : q[0]);
                end
                if (q.size() != 0) void'(q.pop_front());
                got++;
                occ--;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b));
                sent++;
                occ++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (got !== 6) begin
            n_fail++;
            $display("FAIL bp_count got=%0d want=6", got);
        end
        n_cmp++;
        if (low_cnt == 0) begin
            n_fail++;
            $display("FAIL bp_stall got=%0d want>0 in_ready low cycles",
                     low_cnt);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_dup got=%b want=0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic v1;
        out_ready = 1'b0;
        in_valid = 1'b1;
        a = 4'b0001; b = 4'b0001;
        tick();
        a = 4'b0010; b = 4'b0001;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_full got=%b want=10", {out_valid, in_ready});
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, diff, ovf, zero} !== '0) begin
            n_fail++;
            $display("FAIL rst_async got=%b want=0",
                     {out_valid, diff, ovf, zero});
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_in_ready got=%b want=1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        xfer(4'b0100, 4'b0001, v1);
        n_cmp++;
        if (v1 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_stale got=%b want=0", v1);
        end
        n_cmp++;
        if ({out_valid, diff, ovf, zero} !== {1'b1, 4'b0011, 2'b00}) begin
            n_fail++;
            $display("FAIL rst_first got=%b want=%b",
                     {out_valid, diff, ovf, zero}, {1'b1, 4'b0011, 2'b00});
        end
    endtask

    initial begin
        test_reset();
        test_same_sign();
        test_sign_flip();
        test_overflow();
        test_zero_norm();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
